// File: rtl/pipe_credit_sink_pkg.sv
// Shared sizing helpers and parameter sanity checks for the credit sink and its FIFO.
package pipe_credit_sink_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Pointer width; a single-entry FIFO still gets a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int depth, input int latency);
        return (depth >= 1) && (latency >= 0);
    endfunction

endpackage

// File: rtl/pipe_credit_sink_fifo.sv
// Capture FIFO: DW x DEPTH storage with wrap at DEPTH-1 (any DEPTH) and an occupancy count.
module pcs_fifo
    import pipe_credit_sink_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count
);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok, rd_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_ok    = rd_en && (count_q != '0);
        // A write into a full FIFO only lands if a read frees a slot in the same cycle.
        wr_ok    = wr_en && ((count_q != CW'(DEPTH)) || rd_ok);
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = nxt(wr_ptr_q);
        end
        if (rd_ok) rd_ptr_d = nxt(rd_ptr_q);
        if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
        else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pipe_credit_sink.sv
// Credit-gated sink for a fixed-latency delay line: issues slots against free FIFO space,
// tracks in-flight words with a valid shift register and re-times them onto valid/ready.
module pipe_credit_sink
    import pipe_credit_sink_pkg::*;
#(
    parameter int  LATENCY = 2,
    parameter int  DW      = 32,
    parameter int  DEPTH   = 4,
    localparam int CW      = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_req,
    output logic          issue_gnt,
    input  logic [DW-1:0] pipe_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] credits,
    output logic [CW-1:0] occupancy
);
    logic [CW-1:0] cred_q, cred_d;
    logic          pop, arrive;
    int            inflight;

    if (!params_ok(DEPTH, LATENCY)) begin : g_bad_params
        $error("pipe_credit_sink: DEPTH must be >= 1 and LATENCY >= 0");
    end

    // Gated by rst_n so no launch is acknowledged while the line is held in reset.
    assign issue_gnt = rst_n & issue_req & (cred_q != '0);
    assign m_valid   = (occupancy != '0);
    assign pop       = m_valid & m_ready;
    assign credits   = cred_q;

    always_comb begin
        cred_d = cred_q;
        if (issue_gnt && !pop)      cred_d = cred_q - 1'b1;
        else if (!issue_gnt && pop) cred_d = cred_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cred_q <= CW'(DEPTH);
        else        cred_q <= cred_d;
    end

    if (LATENCY == 0) begin : g_lat0
        assign arrive   = issue_gnt;
        assign inflight = 0;
    end else begin : g_shift
        logic [LATENCY-1:0] vld_q, vld_d;

        always_comb begin
            vld_d    = vld_q << 1;
            vld_d[0] = issue_gnt;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_q <= '0;
            else        vld_q <= vld_d;
        end

        assign arrive   = vld_q[LATENCY-1];
        assign inflight = $countones(vld_q);
    end

    pcs_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arrive),
        .wr_data (pipe_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (occupancy)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(arrive && (occupancy == CW'(DEPTH)) && !pop))
                else $error("pipe_credit_sink: arrival into full FIFO, word dropped");
            assert ((int'(cred_q) + int'(occupancy) + inflight) == DEPTH)
                else $error("pipe_credit_sink: credit invariant broken");
        end
    end
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Three sink instances (L2/D4, L0/D1, L1/D3) fed by behavioural delay lines and checked
// each cycle against a queue-based model of credits, in-flight words and stored words.
module tb_pipe_credit_sink;
    localparam int NI = 3;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    logic        clk;
    logic        rst_n;
    logic        req     [NI];
    logic        rdy     [NI];
    logic        gnt     [NI];
    logic        mv      [NI];
    logic [31:0] in_data [NI];
    logic [31:0] pdata   [NI];
    logic [31:0] mdata   [NI];
    logic [2:0]  cred    [NI];
    logic [2:0]  occ     [NI];

    int          n_chk;
    int          n_err;

    // model: free credits, stored words, in-flight words with their ages
    int          mcred [NI];
    logic [31:0] mq    [NI][$];
    logic [31:0] fd    [NI][$];
    int          fa    [NI][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = lat_of(g);
        localparam int D = dep_of(g);
        localparam int C = $clog2(D + 1);
        logic [C-1:0] cred_w, occ_w;

        if (L == 0) begin : g_dl0
            assign pdata[g] = in_data[g];
        end else begin : g_dl
            logic [31:0] dl [L];
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < L; i++) dl[i] <= '0;
                end else begin
                    dl[0] <= in_data[g];
                    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
                end
            end
            assign pdata[g] = dl[L-1];
        end

        pipe_credit_sink #(
            .LATENCY (L),
            .DW      (32),
            .DEPTH   (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .issue_req (req[g]),
            .issue_gnt (gnt[g]),
            .pipe_data (pdata[g]),
            .m_valid   (mv[g]),
            .m_ready   (rdy[g]),
            .m_data    (mdata[g]),
            .credits   (cred_w),
            .occupancy (occ_w)
        );

        assign cred[g] = 3'(cred_w);
        assign occ[g]  = 3'(occ_w);
    end

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, g, obs, exp);
            end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            mcred[g] = dep_of(g);
            mq[g].delete();
            fd[g].delete();
            fa[g].delete();
        end
    endtask

    // Called at a negedge with inputs already driven: check, advance one clock, return at next negedge.
    task automatic cyc();
        bit mg [NI];
        bit mp [NI];
        #1;
        for (int g = 0; g < NI; g++) begin
            mg[g] = rst_n && req[g] && (mcred[g] > 0);
            mp[g] = (mq[g].size() > 0) && rdy[g];
            chk("issue_gnt", g, 32'(gnt[g]), 32'(mg[g]));
            chk("m_valid", g, 32'(mv[g]), 32'(mq[g].size() > 0));
            if (mq[g].size() > 0) chk("m_data", g, mdata[g], mq[g][0]);
            chk("credits", g, 32'(cred[g]), 32'(mcred[g]));
            chk("occupancy", g, 32'(occ[g]), 32'(mq[g].size()));
            chk("invariant", g, 32'(int'(cred[g]) + int'(occ[g]) + fd[g].size()), 32'(dep_of(g)));
        end
        @(posedge clk);
        if (rst_n) begin
            for (int g = 0; g < NI; g++) begin
                if (mp[g]) void'(mq[g].pop_front());
                for (int i = 0; i < fa[g].size(); i++) fa[g][i]++;
                while (fa[g].size() > 0 && fa[g][0] == lat_of(g)) begin
                    mq[g].push_back(fd[g].pop_front());
                    void'(fa[g].pop_front());
                end
                if (mg[g]) begin
                    if (lat_of(g) == 0) mq[g].push_back(in_data[g]);
                    else begin
                        fd[g].push_back(in_data[g]);
                        fa[g].push_back(0);
                    end
                end
                mcred[g] = mcred[g] + int'(mp[g]) - int'(mg[g]);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit y);
        for (int g = 0; g < NI; g++) begin
            req[g]     = r;
            rdy[g]     = y;
            in_data[g] = $urandom;
        end
    endtask

    task automatic drive_rand(input int req_pct);
        for (int g = 0; g < NI; g++) begin
            req[g]     = ($urandom_range(99) < req_pct);
            rdy[g]     = $urandom_range(1);
            in_data[g] = $urandom;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        repeat (2) cyc();
        rst_n = 1'b1;

        // streaming, then full backpressure, then release
        repeat (15) begin drive(1'b1, 1'b1); cyc(); end
        repeat (10) begin drive(1'b1, 1'b0); cyc(); end
        repeat (10) begin drive(1'b1, 1'b1); cyc(); end

        // alternating pop opportunities with continuous requests
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, c[0]);
            cyc();
        end

        // random traffic, then sparse requests to exercise arrive+pop at empty
        repeat (80) begin drive_rand(75); cyc(); end
        repeat (40) begin drive_rand(30); cyc(); end

        // drain, then leave two words stored and one in flight on the L2/D4 instance
        repeat (8) begin drive(1'b0, 1'b1); cyc(); end
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        drive(1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0); cyc();
        chk("pre_reset_stored", 0, 32'(occ[0]), 32'd2);

        drive(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("reset_m_valid", g, 32'(mv[g]), 32'd0);
            chk("reset_m_data", g, mdata[g], 32'd0);
            chk("reset_credits", g, 32'(cred[g]), 32'(dep_of(g)));
            chk("reset_issue_gnt", g, 32'(gnt[g]), 32'd0);
        end
        model_reset();
        cyc();
        rst_n = 1'b1;

        repeat (60) begin drive_rand(70); cyc(); end
        repeat (10) begin drive(1'b0, 1'b1); cyc(); end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
